// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - opcodes, byte-enable constants and FSM encodings for dmem_ctrl
package dmem_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_BUSY = 2'd1,
        DM_DONE = 2'd2
    } dm_state_e;

    // Expand byte enables into a 32-bit lane mask for store-data gating.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - req/ack data-memory bus between dmem_ctrl and memory
interface dmem_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_ctrl_be_gen.sv
// rtl/dmem_ctrl_be_gen.sv - decodes op + low address bits into byte enables and misalign flag
module dmem_ctrl_be_gen
    import dmem_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [1:0] addr_lo_i,
    output logic       valid_o,
    output logic       is_load_o,
    output logic [3:0] be_o,
    output logic       misalign_o
);

    always_comb begin
        valid_o    = 1'b0;
        is_load_o  = 1'b0;
        be_o       = BE_NONE;
        misalign_o = 1'b0;
        unique case (op_i)
            OP_LB, OP_LBU: begin
                valid_o   = 1'b1;
                is_load_o = 1'b1;
                be_o      = BE_WORD;
            end
            OP_LH, OP_LHU: begin
                valid_o    = 1'b1;
                is_load_o  = 1'b1;
                be_o       = BE_WORD;
                misalign_o = addr_lo_i[0];
            end
            OP_LW: begin
                valid_o    = 1'b1;
                is_load_o  = 1'b1;
                be_o       = BE_WORD;
                misalign_o = |addr_lo_i;
            end
            OP_SB: begin
                valid_o = 1'b1;
                be_o    = BE_BYTE0 << addr_lo_i;
            end
            OP_SH: begin
                valid_o    = 1'b1;
                be_o       = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                misalign_o = addr_lo_i[0];
            end
            OP_SW: begin
                valid_o    = 1'b1;
                be_o       = BE_WORD;
                misalign_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage load/store controller driving a req/ack data-memory bus
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic [5:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              adel,
    output logic              ades,
    output logic              bus_err,
    dmem_ctrl_if.master       bus
);

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    dm_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic        req_q;
    logic        we_q;
    logic        load_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic        err_q;

    logic        op_valid;
    logic        op_load;
    logic [3:0]  op_be;
    logic        op_misalign;

    dmem_ctrl_be_gen u_be_gen (
        .op_i       (op),
        .addr_lo_i  (addr[1:0]),
        .valid_o    (op_valid),
        .is_load_o  (op_load),
        .be_o       (op_be),
        .misalign_o (op_misalign)
    );

    // Decode is only meaningful in IDLE; DONE ignores the still-presented instruction.
    // rst_n gates the combinational outputs so a reset clears them immediately.
    logic present;
    logic accept;
    assign present = rst_n && (state_q == DM_IDLE) && mem_en && op_valid;
    assign accept  = present && !op_misalign;

    assign stall = accept || (state_q == DM_BUSY);
    assign adel  = present && op_misalign && op_load;
    assign ades  = present && op_misalign && !op_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DM_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            load_q   <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                DM_IDLE: begin
                    if (accept) begin
                        state_q <= DM_BUSY;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= !op_load;
                        load_q  <= op_load;
                        addr_q  <= {addr[31:2], 2'b00};
                        be_q    <= op_be;
                        wdata_q <= op_load ? 32'h0 : (wdata & be_to_mask(op_be));
                    end
                end
                DM_BUSY: begin
                    // Ack takes priority over the timeout expiring in the same cycle.
                    if (bus.bus_ack) begin
                        state_q <= DM_DONE;
                        req_q   <= 1'b0;
                        if (load_q) begin
                            rdata_q  <= bus.bus_rdata;
                            rvalid_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DM_DONE;
                        req_q   <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DM_DONE: state_q <= DM_IDLE;
                default: state_q <= DM_IDLE;
            endcase
        end
    end

    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign bus_err       = err_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        mem_en;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rvalid;
    logic        adel;
    logic        ades;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_ctrl_if bus_if ();

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_en  (mem_en),
        .op      (op),
        .addr    (addr),
        .wdata   (wdata),
        .stall   (stall),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .adel    (adel),
        .ades    (ades),
        .bus_err (bus_err),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after a rising edge; checks happen 3 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_en = 1'b0; op = 6'h00; addr = '0; wdata = '0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        #12;
        n_checks++; if ({stall, rvalid, adel, ades, bus_err} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {stall, rvalid, adel, ades, bus_err}); end
        n_checks++; if ({bus_if.bus_req, bus_if.bus_we} !== 2'b00) begin n_fail++; $display("FAIL reset_req_we: got %b expected 00", {bus_if.bus_req, bus_if.bus_we}); end
        n_checks++; if (bus_if.bus_addr !== 32'h0 || bus_if.bus_be !== 4'h0) begin n_fail++; $display("FAIL reset_addr_be: got %h/%b expected 0/0000", bus_if.bus_addr, bus_if.bus_be); end
        n_checks++; if (bus_if.bus_wdata !== 32'h0 || rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", bus_if.bus_wdata, rdata); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sb_store();
        int stall_cycles = 0;
        mem_en = 1'b1; op = OP_SB; addr = 32'h0000_1003; wdata = 32'hAB00_0000;
        #3;
        if (stall === 1'b1) stall_cycles++;
        n_checks++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL sb_req_accept: got %b expected 0", bus_if.bus_req); end
        step(); #3;
        if (stall === 1'b1) stall_cycles++;
        n_checks++; if (bus_if.bus_req !== 1'b1) begin n_fail++; $display("FAIL sb_req_busy: got %b expected 1", bus_if.bus_req); end
        n_checks++; if (bus_if.bus_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr: got %h expected 00001000", bus_if.bus_addr); end
        n_checks++; if (bus_if.bus_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b expected 1000", bus_if.bus_be); end
        n_checks++; if (bus_if.bus_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b expected 1", bus_if.bus_we); end
        n_checks++; if (bus_if.bus_wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_wdata: got %h expected ab000000", bus_if.bus_wdata); end
        step(); bus_if.bus_ack = 1'b1; #3;
        if (stall === 1'b1) stall_cycles++;
        n_checks++; if (bus_if.bus_be !== 4'b1000 || bus_if.bus_req !== 1'b1) begin n_fail++; $display("FAIL sb_hold: got be=%b req=%b expected be=1000 req=1", bus_if.bus_be, bus_if.bus_req); end
        step(); bus_if.bus_ack = 1'b0; #3;
        if (stall === 1'b1) stall_cycles++;
        n_checks++; if (rvalid !== 1'b0 || bus_err !== 1'b0 || bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL sb_done: got rvalid=%b err=%b req=%b expected 0 0 0", rvalid, bus_err, bus_if.bus_req); end
        n_checks++; if (stall_cycles !== 3) begin n_fail++; $display("FAIL sb_stall_cycles: got %0d expected 3", stall_cycles); end
        step(); mem_en = 1'b0;
    endtask

    task automatic test_lw_load();
        mem_en = 1'b1; op = OP_LW; addr = 32'h0000_2000; wdata = 32'hFFFF_FFFF;
        #3;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_stall_accept: got %b expected 1", stall); end
        step(); bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF; #3;
        n_checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b0 || bus_if.bus_be !== 4'b1111) begin n_fail++; $display("FAIL lw_busy_bus: got req=%b we=%b be=%b expected 1 0 1111", bus_if.bus_req, bus_if.bus_we, bus_if.bus_be); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_stall_busy: got %b expected 1", stall); end
        step(); bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0; #3;
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", rdata); end
        n_checks++; if (rvalid !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL lw_done: got rvalid=%b stall=%b expected 1 0", rvalid, stall); end
        step(); mem_en = 1'b0; #3;
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL lw_rvalid_pulse: got %b expected 0", rvalid); end
        step();
    endtask

    task automatic test_misaligned();
        mem_en = 1'b1; op = OP_LH; addr = 32'h0000_2001; #3;
        n_checks++; if ({adel, ades, stall} !== 3'b100) begin n_fail++; $display("FAIL lh_misalign: got adel/ades/stall=%b expected 100", {adel, ades, stall}); end
        step(); op = OP_SW; addr = 32'h0000_2002; #3;
        n_checks++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL lh_no_req: got %b expected 0", bus_if.bus_req); end
        n_checks++; if ({adel, ades, stall} !== 3'b010) begin n_fail++; $display("FAIL sw_misalign: got adel/ades/stall=%b expected 010", {adel, ades, stall}); end
        step(); op = 6'h00; addr = 32'h0000_2000; #3;
        n_checks++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL sw_no_req: got %b expected 0", bus_if.bus_req); end
        n_checks++; if ({adel, ades, stall} !== 3'b000) begin n_fail++; $display("FAIL unknown_op: got adel/ades/stall=%b expected 000", {adel, ades, stall}); end
        step(); mem_en = 1'b0; #3;
        n_checks++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL unknown_no_req: got %b expected 0", bus_if.bus_req); end
        step();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        mem_en = 1'b1; op = OP_LW; addr = 32'h0000_2004;
        for (int i = 0; i < 5; i++) begin
            step(); #3;
            if (bus_if.bus_req === 1'b1) req_cycles++;
        end
        n_checks++; if (req_cycles !== 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d expected 4", req_cycles); end
        n_checks++; if (bus_err !== 1'b1 || rvalid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL to_done: got err=%b rvalid=%b stall=%b expected 1 0 0", bus_err, rvalid, stall); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h expected 00000000", rdata); end
        step(); mem_en = 1'b0; #3;
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %b expected 0", bus_err); end
        step();
    endtask

    task automatic test_ack_at_timeout();
        mem_en = 1'b1; op = OP_LW; addr = 32'h0000_2008;
        for (int i = 0; i < 4; i++) step();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
        step(); bus_if.bus_ack = 1'b0; #3;
        n_checks++; if (rvalid !== 1'b1 || bus_err !== 1'b0) begin n_fail++; $display("FAIL ack_limit_done: got rvalid=%b err=%b expected 1 0", rvalid, bus_err); end
        n_checks++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ack_limit_rdata: got %h expected 12345678", rdata); end
        step(); mem_en = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        mem_en = 1'b1; op = OP_SH; addr = 32'h0000_3002; wdata = 32'h5566_AAAA;
        step(); bus_if.bus_ack = 1'b1; #3;
        n_checks++; if (bus_if.bus_be !== 4'b1100 || bus_if.bus_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL b2b_sh_bus: got be=%b addr=%h expected 1100 00003000", bus_if.bus_be, bus_if.bus_addr); end
        n_checks++; if (bus_if.bus_wdata !== 32'h5566_0000) begin n_fail++; $display("FAIL b2b_sh_wdata: got %h expected 55660000", bus_if.bus_wdata); end
        step(); bus_if.bus_ack = 1'b0; #3;
        n_checks++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_no_reissue: got req=%b stall=%b expected 0 0", bus_if.bus_req, stall); end
        step(); op = OP_LBU; addr = 32'h0000_3003; #3;
        n_checks++; if (stall !== 1'b1 || bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got stall=%b req=%b expected 1 0", stall, bus_if.bus_req); end
        step(); bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0000_00C3; #3;
        n_checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_be !== 4'b1111 || bus_if.bus_we !== 1'b0) begin n_fail++; $display("FAIL b2b_lbu_bus: got req=%b be=%b we=%b expected 1 1111 0", bus_if.bus_req, bus_if.bus_be, bus_if.bus_we); end
        n_checks++; if (bus_if.bus_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL b2b_lbu_addr: got %h expected 00003000", bus_if.bus_addr); end
        step(); bus_if.bus_ack = 1'b0; #3;
        n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h0000_00C3) begin n_fail++; $display("FAIL b2b_lbu_done: got rvalid=%b rdata=%h expected 1 000000c3", rvalid, rdata); end
        step(); mem_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b1; op = OP_SW; addr = 32'h0000_4000; wdata = 32'h1122_3344;
        step(); #3;
        n_checks++; if (bus_if.bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_req: got %b expected 1", bus_if.bus_req); end
        rst_n = 1'b0; #1;
        n_checks++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_async: got req=%b stall=%b expected 0 0", bus_if.bus_req, stall); end
        n_checks++; if (bus_if.bus_addr !== 32'h0 || rdata !== 32'h0) begin n_fail++; $display("FAIL rst_async_clear: got addr=%h rdata=%h expected 0 0", bus_if.bus_addr, rdata); end
        step(); mem_en = 1'b0; #1; rst_n = 1'b1;
        step(); bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D; #3;
        n_checks++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack: got req=%b stall=%b expected 0 0", bus_if.bus_req, stall); end
        step(); bus_if.bus_ack = 1'b0; #3;
        n_checks++; if (rvalid !== 1'b0 || rdata !== 32'h0 || bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_ack_ignored: got rvalid=%b rdata=%h req=%b expected 0 0 0", rvalid, rdata, bus_if.bus_req); end
        step();
    endtask

    initial begin
        test_reset();
        test_sb_store();
        test_lw_load();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
